// File: rtl/calc_pkg.sv
// Shared encodings for the calc_unit slice: operation codes and FSM states.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } calc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } calc_state_e;

endpackage

// File: rtl/calc_if.sv
// Request/response bundle between a requester (master) and calc_unit (slave).
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
interface calc_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 flag;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag
    );
endinterface

// File: rtl/calc_mul_seq.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle.
// Bit 0 is folded into the start edge so the final product is ready WIDTH-1 edges later.
module calc_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    assign a_ext = {{WIDTH{1'b0}}, a};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            acc    <= b[0] ? a_ext : '0;
            mcand  <= a_ext << 1;
            mplier <= b >> 1;
            cnt    <= CW'(1);
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == CW'(WIDTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
                cnt  <= '0;
            end else begin
                cnt  <= cnt + CW'(1);
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign product = acc;

endmodule

// File: rtl/calc_unit.sv
// Single-issue arithmetic unit: add/sub complete in one cycle, multiply uses
// the sequential shift-add engine. Results are held until the consumer takes them.
module calc_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    calc_if.slave        bus,
    output calc_state_e  state
);
    calc_state_e          state_q;
    calc_state_e          state_d;
    calc_op_e             op_in;
    logic                 accept;
    logic                 start_mul;
    logic                 mul_busy;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   alu_result;
    logic                 alu_flag;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 flag_q;

    assign op_in = calc_op_e'(bus.op);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = start_mul ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_done) state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Requests are only looked at in IDLE; anything on the inputs elsewhere is ignored.
    always_comb begin
        accept    = 1'b0;
        start_mul = 1'b0;
        if (state_q == ST_IDLE && bus.in_valid) begin
            accept    = 1'b1;
            start_mul = (op_in == OP_MUL);
        end
    end

    always_comb begin
        sum        = {1'b0, bus.a} + {1'b0, bus.b};
        alu_result = '0;
        alu_flag   = 1'b0;
        case (op_in)
            OP_ADD: begin
                alu_result[WIDTH-1:0] = sum[WIDTH-1:0];
                alu_flag              = sum[WIDTH];
            end
            OP_SUB: begin
                if (bus.a < bus.b) begin
                    alu_result[WIDTH-1:0] = bus.b - bus.a;
                    alu_flag              = 1'b1;
                end else begin
                    alu_result[WIDTH-1:0] = bus.a - bus.b;
                end
            end
            OP_RSVD: alu_flag = 1'b1;
            default: ;
        endcase
    end

    calc_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_mul),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    // Handshake flags are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_q      <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            if (accept && !start_mul) begin
                result_q <= alu_result;
                flag_q   <= alu_flag;
            end else if (state_q == ST_MUL && mul_done && !mul_busy) begin
                result_q <= product;
                flag_q   <= |product[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag      = flag_q;
    assign state         = state_q;

endmodule

// File: doc/calc_unit.md
CALC_UNIT -- requirements
Module: calc_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal values are 2 to 32.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 The module SHALL have port in_valid, input, 1 bit, meaning an operation request is present.
REQ-005 The module SHALL have port in_ready, output, 1 bit, meaning the unit can accept a request.
REQ-006 The module SHALL have port op, input, 2 bits: 00 add, 01 subtract, 10 multiply, 11 reserved.
REQ-007 The module SHALL have ports a and b, inputs, WIDTH bits each, holding unsigned operands.
REQ-008 The module SHALL have port out_valid, output, 1 bit, meaning the result is present.
REQ-009 The module SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-010 The module SHALL have port result, output, 2*WIDTH bits, holding the registered result.
REQ-011 The module SHALL have port flag, output, 1 bit, holding the registered status flag defined per op.

Function
REQ-012 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; op, a and b are captured internally on that edge.
REQ-013 in_ready SHALL be 1 only in state IDLE, so at most one operation is in flight.
REQ-014 The FSM SHALL have three states, IDLE, MUL and DONE, with these transitions: IDLE->DONE on accepting add, subtract or reserved; IDLE->MUL on accepting multiply; MUL->DONE after exactly WIDTH iteration edges; DONE->IDLE on an edge with out_ready=1.
REQ-015 Add SHALL set result[WIDTH-1:0] to (a+b) mod 2^WIDTH, set the upper WIDTH bits to zero, and set flag to the carry-out.
REQ-016 Subtract SHALL set result[WIDTH-1:0] to |a-b| (magnitude), set the upper bits to zero, and set flag to 1 only when a<b; a==b SHALL give result 0, flag 0.
REQ-017 Multiply SHALL use a radix-2 shift-add that processes one multiplier bit per cycle; result SHALL be the full 2*WIDTH-bit product, and flag SHALL be 1 when result[2*WIDTH-1:WIDTH] is nonzero.
REQ-018 The reserved op SHALL give result 0 and flag 1.
REQ-019 Latency SHALL be: out_valid=1 one cycle after acceptance for add, subtract and reserved; WIDTH+1 cycles after acceptance for multiply.
REQ-020 out_valid SHALL be 1 exactly in state DONE; result and flag SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 out_valid, result and flag SHALL change only on acceptance or completion; in_valid, op, a and b SHALL be ignored outside IDLE.
REQ-022 The operand mux and the result computation SHALL be free of latches; every output SHALL be driven from a flop.

Reset
REQ-023 On a rising edge with rst_n=0, the state SHALL become IDLE, and out_valid, result, flag and the iteration counter SHALL be 0.
REQ-024 Reset SHALL take priority over all other events, including mid-MUL and DONE with out_ready=1; the in-flight result SHALL be discarded with no out_valid pulse.
REQ-025 in_ready SHALL be 1 on the first edge after rst_n returns to 1.

Structure
REQ-026 The shared package calc_pkg SHALL hold the op encoding enum (OP_ADD, OP_SUB, OP_MUL, OP_RSVD) and the FSM state enum.
REQ-027 The shift-add engine SHALL be a sub-module calc_mul_seq (ports: start, a, b, busy, done, product), parametrised by WIDTH.
REQ-028 Add and subtract SHALL be combinational logic inside calc_unit, registered into result and flag.

Verification (WIDTH=4 unless stated)
REQ-029 Add test: add a=9, b=8 -> one cycle later out_valid=1, result=0x01, flag=1; add 3+4 -> result=0x07, flag=0.
REQ-030 Subtract test: sub a=3, b=5 -> result=0x02, flag=1; sub 5,3 -> result=0x02, flag=0; sub 6,6 -> result=0x00, flag=0.
REQ-031 Multiply test: mul 15*15 -> out_valid exactly 5 cycles after acceptance, result=0xE1, flag=1; mul 3*5 -> result=0x0F, flag=0; in_ready=0 throughout.
REQ-032 Backpressure test: hold out_ready=0 for 4 cycles in DONE while toggling a, b and in_valid -> result, flag and out_valid stay unchanged and nothing new is accepted; then out_ready=1 -> in_ready=1 on the next cycle.
REQ-033 Reset and reserved test: assert rst_n=0 two cycles into mul 7*9 -> all outputs 0 and state IDLE, with no out_valid pulse; then op=11 -> result=0, flag=1.
REQ-034 WIDTH=8 test: mul 255*255 -> result=0xFE01 at 9 cycles after acceptance; add 200+100 -> result=0x002C, flag=1.
